// File: rtl/iob_ibus_dbus_arbiter.sv
// iob_ibus_dbus_arbiter: round-robin share of one IOb memory port between CPU ibus and dbus
// Ports: clk_i/arst_i/cke_i clock, async active-high reset, clock enable;
//        i_* ibus slave port, d_* dbus slave port, m_* memory master port;
//        grant_o registered one-hot owner {dbus,ibus}, 00 when idle.
module iob_ibus_dbus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic                cke_i,
    input  logic                i_avalid_i,
    input  logic [ADDR_W-1:0]   i_addr_i,
    input  logic [DATA_W-1:0]   i_wdata_i,
    input  logic [DATA_W/8-1:0] i_wstrb_i,
    output logic [DATA_W-1:0]   i_rdata_o,
    output logic                i_rvalid_o,
    output logic                i_ready_o,
    input  logic                d_avalid_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    input  logic [DATA_W/8-1:0] d_wstrb_i,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                d_rvalid_o,
    output logic                d_ready_o,
    output logic                m_avalid_o,
    output logic [ADDR_W-1:0]   m_addr_o,
    output logic [DATA_W-1:0]   m_wdata_o,
    output logic [DATA_W/8-1:0] m_wstrb_o,
    input  logic [DATA_W-1:0]   m_rdata_i,
    input  logic                m_rvalid_i,
    input  logic                m_ready_i,
    output logic [1:0]          grant_o
);
    typedef enum logic [1:0] {IDLE, HOLD, WAIT_R} state_t;
    state_t state, state_n;
    logic owner, owner_n, last, last_n, sel, sel_av, fwd, acc, rd;
    always_comb begin
        // on a tie the bus not served last wins; outside IDLE the owner is locked
        sel       = (state == IDLE) ? ((i_avalid_i && d_avalid_i) ? ~last : d_avalid_i) : owner;
        sel_av    = sel ? d_avalid_i : i_avalid_i;
        fwd       = (state != WAIT_R) && sel_av;
        m_avalid_o = fwd;
        m_addr_o  = fwd ? (sel ? d_addr_i : i_addr_i) : '0;
        m_wdata_o = fwd ? (sel ? d_wdata_i : i_wdata_i) : '0;
        m_wstrb_o = fwd ? (sel ? d_wstrb_i : i_wstrb_i) : '0;
        i_ready_o = fwd && !sel && m_ready_i;
        d_ready_o = fwd && sel && m_ready_i;
        i_rdata_o = m_rdata_i;
        d_rdata_o = m_rdata_i;
        i_rvalid_o = (state == WAIT_R) && !owner && m_rvalid_i;
        d_rvalid_o = (state == WAIT_R) && owner && m_rvalid_i;
        rd        = (m_wstrb_o == '0);
        acc       = fwd && m_ready_i;
        state_n   = (state == WAIT_R) ? (m_rvalid_i ? IDLE : WAIT_R) :
                    !fwd ? IDLE : !m_ready_i ? HOLD : rd ? WAIT_R : IDLE;
        // owner only needs to be captured when the bus stays locked (stall or read)
        owner_n   = (fwd && !(acc && !rd)) ? sel : owner;
        last_n    = acc ? sel : last;
    end
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b0;
        end else if (cke_i) begin
            state <= state_n;
            owner <= owner_n;
            last  <= last_n;
        end
    end
    assign grant_o = (state == IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);
endmodule

// File: tb/tb_iob_ibus_dbus_arbiter.sv
// tb_iob_ibus_dbus_arbiter: directed plus randomized check of the arbiter against a bus-level model
module tb_iob_ibus_dbus_arbiter;
    logic clk = 0, arst = 1, cke = 1;
    logic i_av = 0, d_av = 0, m_ready = 0, m_rvalid = 0;
    logic [31:0] i_addr = 0, d_addr = 0, i_wdata = 0, d_wdata = 0, m_rdata = 0;
    logic [3:0] i_wstrb = 0, d_wstrb = 0;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic [3:0] m_wstrb;
    logic i_rvalid, i_ready, d_rvalid, d_ready, m_avalid;
    logic [1:0] grant;
    int tests = 0, fails = 0;
    // model: pending = bus awaiting read data, locked = bus stalled at the port, -1 = none
    int pending, locked, last_srv, e_bus;
    logic e_fwd;

    iob_ibus_dbus_arbiter dut (
        .clk_i(clk), .arst_i(arst), .cke_i(cke),
        .i_avalid_i(i_av), .i_addr_i(i_addr), .i_wdata_i(i_wdata), .i_wstrb_i(i_wstrb),
        .i_rdata_o(i_rdata), .i_rvalid_o(i_rvalid), .i_ready_o(i_ready),
        .d_avalid_i(d_av), .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_wstrb_i(d_wstrb),
        .d_rdata_o(d_rdata), .d_rvalid_o(d_rvalid), .d_ready_o(d_ready),
        .m_avalid_o(m_avalid), .m_addr_o(m_addr), .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb),
        .m_rdata_i(m_rdata), .m_rvalid_i(m_rvalid), .m_ready_i(m_ready), .grant_o(grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pending = -1; locked = -1; last_srv = 0;
    endtask

    function automatic logic [1:0] onehot(input int b);
        return (b < 0) ? 2'b00 : (b == 1 ? 2'b10 : 2'b01);
    endfunction

    task automatic eval_now();
        logic [31:0] ea, ew;
        logic [3:0] es;
        @(negedge clk);
        e_bus = -1;
        if (pending < 0) begin
            if (locked >= 0) e_bus = locked;
            else if (i_av && d_av) e_bus = 1 - last_srv;
            else if (d_av) e_bus = 1;
            else if (i_av) e_bus = 0;
        end
        e_fwd = (e_bus == 1) ? d_av : (e_bus == 0) ? i_av : 1'b0;
        ea = !e_fwd ? 0 : (e_bus == 1 ? d_addr : i_addr);
        ew = !e_fwd ? 0 : (e_bus == 1 ? d_wdata : i_wdata);
        es = !e_fwd ? 0 : (e_bus == 1 ? d_wstrb : i_wstrb);
        chk("m_avalid", 32'(m_avalid), 32'(e_fwd));
        chk("m_addr", m_addr, ea);
        chk("m_wdata", m_wdata, ew);
        chk("m_wstrb", 32'(m_wstrb), 32'(es));
        chk("i_ready", 32'(i_ready), 32'(e_fwd && e_bus == 0 && m_ready));
        chk("d_ready", 32'(d_ready), 32'(e_fwd && e_bus == 1 && m_ready));
        chk("i_rvalid", 32'(i_rvalid), 32'(pending == 0 && m_rvalid));
        chk("d_rvalid", 32'(d_rvalid), 32'(pending == 1 && m_rvalid));
        chk("i_rdata", i_rdata, m_rdata);
        chk("d_rdata", d_rdata, m_rdata);
        chk("grant", 32'(grant), 32'(onehot(pending >= 0 ? pending : locked)));
    endtask

    task automatic advance();
        @(posedge clk);
        if (arst) model_reset();
        else if (cke) begin
            if (pending >= 0) begin
                if (m_rvalid) pending = -1;
            end else if (e_fwd) begin
                if (m_ready) begin
                    last_srv = e_bus;
                    locked = -1;
                    if (es_read(e_bus)) pending = e_bus;
                end else locked = e_bus;
            end else locked = -1;
        end
        #1;
    endtask

    function automatic logic es_read(input int b);
        return (b == 1 ? d_wstrb : i_wstrb) == 4'h0;
    endfunction

    task automatic drive(input logic ia, input logic [31:0] ad_i, input logic [3:0] si,
                         input logic da, input logic [31:0] ad_d, input logic [3:0] sd,
                         input logic rdy, input logic rv, input logic [31:0] rdat);
        i_av = ia; i_addr = ad_i; i_wstrb = si; i_wdata = ad_i ^ 32'h5555_0000;
        d_av = da; d_addr = ad_d; d_wstrb = sd; d_wdata = ad_d ^ 32'h0000_AAAA;
        m_ready = rdy; m_rvalid = rv; m_rdata = rdat;
    endtask

    initial begin
        model_reset();
        @(posedge clk); #1;
        arst = 0;
        // reset state with idle inputs
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        eval_now();
        chk("reset_grant", 32'(grant), 32'h0);
        advance();
        // single ibus read, data returns one cycle later
        drive(1, 32'h100, 0, 0, 0, 0, 1, 0, 0);
        eval_now();
        chk("ibus_ready_same_cycle", 32'(i_ready), 32'h1);
        advance();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
        eval_now();
        chk("ibus_rdata", i_rdata, 32'hDEADBEEF);
        chk("ibus_rvalid", 32'(i_rvalid), 32'h1);
        chk("wait_grant", 32'(grant), 32'h1);
        advance();
        // fresh reset, then repeated read contention alternates d,i,d,i
        arst = 1; #1; model_reset(); advance(); arst = 0;
        for (int k = 0; k < 4; k++) begin
            drive(1, 32'h200 + k, 0, 1, 32'h300 + k, 0, 1, 0, 0);
            eval_now();
            chk("contention_addr", m_addr, (k % 2 == 0) ? 32'h300 + k : 32'h200 + k);
            advance();
            drive(1, 32'h200 + k, 0, 1, 32'h300 + k, 0, 0, 1, 32'hC0DE0000 + k);
            eval_now();
            advance();
        end
        // stalled dbus write keeps the grant while ibus waits
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        eval_now(); advance();
        for (int c = 1; c <= 5; c++) begin
            drive(c >= 2, 32'h400, 0, c <= 4, 32'h500, 4'hF, c >= 4, 0, 0);
            eval_now();
            if (c >= 2 && c <= 4) chk("hold_grant", 32'(grant), 32'h2);
            if (c <= 4) chk("hold_addr", m_addr, 32'h500);
            if (c == 5) chk("ibus_after_write", m_addr, 32'h400);
            advance();
        end
        // both buses request during an outstanding read; then unsolicited rvalid
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        eval_now(); advance();
        drive(0, 0, 0, 1, 32'h600, 0, 1, 0, 0);
        eval_now(); advance();
        for (int c = 0; c < 3; c++) begin
            drive(1, 32'h700, 0, 1, 32'h600, 0, 1, c == 2, 32'h12345678);
            eval_now();
            chk("wait_no_avalid", 32'(m_avalid), 32'h0);
            advance();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF0000);
        eval_now();
        chk("unsolicited_rvalid", 32'({i_rvalid, d_rvalid}), 32'h0);
        advance();
        // clock enable freeze while waiting for read data
        drive(0, 0, 0, 1, 32'h800, 0, 1, 0, 0);
        eval_now(); advance();
        cke = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA5555);
        eval_now(); advance();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        eval_now();
        chk("cke_frozen_grant", 32'(grant), 32'h2);
        advance();
        cke = 1;
        // asynchronous reset in WAIT_R drops the grant at once; late rvalid ignored
        arst = 1; #1; model_reset();
        chk("arst_grant", 32'(grant), 32'h0);
        eval_now(); advance();
        arst = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 1, 32'hBAD0BAD0);
        eval_now();
        chk("late_rvalid", 32'({i_rvalid, d_rvalid}), 32'h0);
        advance();
        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            cke = ($urandom_range(0, 9) != 0);
            drive($urandom_range(0, 1), $urandom, ($urandom_range(0, 1) != 0) ? 4'(($urandom_range(1, 15))) : 4'h0,
                  $urandom_range(0, 1), $urandom, ($urandom_range(0, 1) != 0) ? 4'(($urandom_range(1, 15))) : 4'h0,
                  $urandom_range(0, 1), ($urandom_range(0, 2) == 0), $urandom);
            eval_now();
            advance();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/iob_ibus_dbus_arbiter.md
Name: iob_ibus_dbus_arbiter

Overview:
- Shares one IOb native memory port between the CPU instruction bus and data bus.
- Typical use: single-ported internal SRAM, or a single external-memory port behind the CPU wrapper.
- Round-robin arbitration between the two buses.
- Holds the grant while a presented request is stalled, and while a read is outstanding until its rvalid returns.

Parameters:
ADDR_W, 32, address width of all three ports
DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
clk_i  in  1  clock
arst_i  in  1  asynchronous reset, active-high
cke_i  in  1  clock enable; when 0 all registers hold
i_avalid_i  in  1  ibus request valid
i_addr_i  in  ADDR_W  ibus address
i_wdata_i  in  DATA_W  ibus write data
i_wstrb_i  in  DATA_W/8  ibus write strobe (0 = read)
i_rdata_o  out  DATA_W  ibus read data
i_rvalid_o  out  1  ibus read data valid
i_ready_o  out  1  ibus request accepted
d_avalid_i, d_addr_i, d_wdata_i, d_wstrb_i, d_rdata_o, d_rvalid_o, d_ready_o  (same directions/widths)  dbus equivalents
m_avalid_o  out  1  memory request valid
m_addr_o  out  ADDR_W  memory address
m_wdata_o  out  DATA_W  memory write data
m_wstrb_o  out  DATA_W/8  memory write strobe
m_rdata_i  in  DATA_W  memory read data
m_rvalid_i  in  1  memory read data valid
m_ready_i  in  1  memory accepts request
grant_o  out  2  registered owner, one-hot {dbus,ibus}; 00 = none

Behaviour:
- Handshake: a request is accepted in a cycle with avalid=1 and ready=1. It is a read if wstrb==0, otherwise a write. Writes complete at acceptance. Reads complete when the memory asserts m_rvalid_i, at least 1 cycle after acceptance.
- Registers: state (IDLE, HOLD, WAIT_R), owner (1 bit: 0=ibus, 1=dbus), last (last served, 1 bit).
- Reset values: state=IDLE, owner=0, last=0, grant_o=00.
- With all inputs 0 after reset, every output is 0.
- IDLE:
  - Combinational select. Only one avalid → that bus. Both → the bus != last (first tie after reset goes to dbus).
  - Selected bus's addr/wdata/wstrb/avalid are forwarded to m_*. m_ready_i is routed to the selected bus's ready. The other bus's ready=0.
  - Neither valid → m_avalid_o=0, m_addr/wdata/wstrb=0.
  - Transitions:
    - Accepted read → WAIT_R, owner=sel, last=sel.
    - Accepted write → stay IDLE, last=sel.
    - Presented but not accepted → HOLD, owner=sel.
- HOLD:
  - Only owner is forwarded and routed, even if the other bus requests.
  - Owner accepted read → WAIT_R. Owner accepted write → IDLE. last=owner in both cases.
  - Owner drops avalid (protocol violation) → IDLE with m_avalid_o=0 that cycle.
- WAIT_R:
  - m_avalid_o=0 and both readies=0.
  - owner's rvalid = m_rvalid_i.
  - m_rvalid_i=1 → IDLE next cycle. One bubble cycle: no new request is forwarded in the rvalid cycle.
- rdata: m_rdata_i is broadcast to both i_rdata_o and d_rdata_o. The rvalid outputs are gated: only the owner in WAIT_R sees rvalid.
- m_rvalid_i in IDLE/HOLD (unsolicited) is ignored; both rvalid outputs stay 0.
- grant_o: onehot(owner) in HOLD/WAIT_R; 00 in IDLE.
- Latency: an uncontended request passes through combinationally (0 added cycles). Back-to-back reads from one bus sustain 1 request per (read latency + 1) cycles.
- cke_i=0: state and registers frozen. Combinational forwarding continues from frozen state; transitions do not occur.
- arst_i mid-operation (e.g. in WAIT_R): immediate return to reset values. An in-flight rvalid arriving afterward is ignored.

Test Plan:
- Reset, all inputs 0 → all outputs 0, grant_o=00. Then:
  - ibus read addr=0x100, m_ready_i=1, m_rdata_i=0xDEADBEEF with m_rvalid_i 1 cycle later → i_ready_o=1 same cycle; i_rvalid_o=1 with i_rdata_o=0xDEADBEEF; d_rvalid_o=0; grant_o=01 during wait.
- Both request reads simultaneously after reset → dbus served first (m_addr_o=d_addr_i). After its rvalid plus 1 bubble, ibus is served. Repeated contention alternates d,i,d,i.
- dbus write wstrb=0xF, m_ready_i held 0 for 3 cycles, ibus asserts in cycle 2 → m_addr_o stays dbus addr, grant_o=10 throughout. Write accepted cycle 4; ibus forwarded cycle 5.
- Read outstanding in WAIT_R, ibus and dbus both assert avalid → m_avalid_o=0, both readies 0 until m_rvalid_i. Unsolicited m_rvalid_i pulse in IDLE → no rvalid output.
- cke_i=0 while in WAIT_R and m_rvalid_i pulses → state unchanged. arst_i pulse in WAIT_R → grant_o=00 immediately; a later m_rvalid_i produces no rvalid output.
